// File: rtl/debounce_toggle_leds.sv
// debounce_toggle_leds
// Multi-channel push-button to LED controller. Each channel runs its raw
// switch through a 2-flop synchroniser, normalises polarity so that
// pressed = 1, debounces with a stability counter and drives its LED in
// toggle mode (flip on each debounced release) or momentary mode (LED
// follows the debounced level). One-cycle press/release pulses are exported.
//
// Ports:
//   i_Clk           system clock, rising edge
//   i_Rst_n         asynchronous active-low reset
//   i_Switch        raw asynchronous switch levels, one bit per channel
//   i_Clear         synchronous clear of all toggle-mode LEDs
//   o_LED           registered LED drive, 1 = lit
//   o_Pressed       debounced level, 1 = pressed
//   o_Press_Pulse   one-cycle pulse on debounced press
//   o_Release_Pulse one-cycle pulse on debounced release
module debounce_toggle_leds #(
  parameter int                NUM_CH            = 4,
  parameter int                DEBOUNCE_CYCLES   = 250000,
  parameter int                SWITCH_ACTIVE_LOW = 1,
  parameter logic [NUM_CH-1:0] TOGGLE_MASK       = {NUM_CH{1'b1}}
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic [NUM_CH-1:0] i_Switch,
  input  logic              i_Clear,
  output logic [NUM_CH-1:0] o_LED,
  output logic [NUM_CH-1:0] o_Pressed,
  output logic [NUM_CH-1:0] o_Press_Pulse,
  output logic [NUM_CH-1:0] o_Release_Pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  // Raw level of a released switch; XOR with it turns the synchronised
  // level into "pressed = 1" regardless of board polarity.
  localparam logic [NUM_CH-1:0] RELEASED =
    (SWITCH_ACTIVE_LOW != 0) ? {NUM_CH{1'b1}} : {NUM_CH{1'b0}};

  logic [NUM_CH-1:0]         r_sync1;
  logic [NUM_CH-1:0]         r_sync2;
  logic [NUM_CH-1:0][CW-1:0] r_cnt;
  logic [NUM_CH-1:0]         r_pressed;
  logic [NUM_CH-1:0]         r_press_pulse;
  logic [NUM_CH-1:0]         r_release_pulse;
  logic [NUM_CH-1:0]         r_led;

  logic [NUM_CH-1:0]         w_level;
  logic [NUM_CH-1:0][CW-1:0] w_cnt_nxt;
  logic [NUM_CH-1:0]         w_pressed_nxt;
  logic [NUM_CH-1:0]         w_press_ev;
  logic [NUM_CH-1:0]         w_release_ev;
  logic [NUM_CH-1:0]         w_led_nxt;

  assign w_level = r_sync2 ^ RELEASED;

  // Two-flop synchroniser, preloaded to the released level so reset never
  // looks like a press.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_sync1 <= RELEASED;
      r_sync2 <= RELEASED;
    end else begin
      r_sync1 <= i_Switch;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce counters, event detection and LED next-state per channel.
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_pressed_nxt = r_pressed;
    w_press_ev    = {NUM_CH{1'b0}};
    w_release_ev  = {NUM_CH{1'b0}};
    w_led_nxt     = r_led;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (w_level[ch] != r_pressed[ch]) begin
        // The new level has now been seen for DEBOUNCE_CYCLES edges.
        if (r_cnt[ch] == CNT_LAST) begin
          w_cnt_nxt[ch]     = {CW{1'b0}};
          w_pressed_nxt[ch] = w_level[ch];
          w_press_ev[ch]    = w_level[ch];
          w_release_ev[ch]  = ~w_level[ch];
        end else begin
          w_cnt_nxt[ch] = r_cnt[ch] + CW'(1);
        end
      end else begin
        // Level returned to the accepted value: reject the glitch.
        w_cnt_nxt[ch] = {CW{1'b0}};
      end

      if (TOGGLE_MASK[ch]) begin
        // Clear wins over a coincident release toggle.
        if (i_Clear) begin
          w_led_nxt[ch] = 1'b0;
        end else if (w_release_ev[ch]) begin
          w_led_nxt[ch] = ~r_led[ch];
        end else begin
          w_led_nxt[ch] = r_led[ch];
        end
      end else begin
        w_led_nxt[ch] = w_pressed_nxt[ch];
      end
    end
  end

  // Debouncer, pulse and LED state registers.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_cnt           <= {(NUM_CH*CW){1'b0}};
      r_pressed       <= {NUM_CH{1'b0}};
      r_press_pulse   <= {NUM_CH{1'b0}};
      r_release_pulse <= {NUM_CH{1'b0}};
      r_led           <= {NUM_CH{1'b0}};
    end else begin
      r_cnt           <= w_cnt_nxt;
      r_pressed       <= w_pressed_nxt;
      r_press_pulse   <= w_press_ev;
      r_release_pulse <= w_release_ev;
      r_led           <= w_led_nxt;
    end
  end

  assign o_LED           = r_led;
  assign o_Pressed       = r_pressed;
  assign o_Press_Pulse   = r_press_pulse;
  assign o_Release_Pulse = r_release_pulse;

endmodule

// File: tb/tb_debounce_toggle_leds.sv
// Bench for debounce_toggle_leds with NUM_CH=2, DEBOUNCE_CYCLES=4,
// active-low switches, ch0 toggle mode and ch1 momentary mode.
// Each table record gives the inputs applied before one clock edge and the
// outputs expected just after it, as {LED, Pressed, Press_Pulse, Release_Pulse}.
module tb_debounce_toggle_leds;

  logic       clk;
  logic       rst_n;
  logic [1:0] sw;
  logic       clr;
  logic [1:0] led;
  logic [1:0] pressed;
  logic [1:0] press_pulse;
  logic [1:0] release_pulse;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] sw;
    logic       clr;
    logic [1:0] led;
    logic [1:0] pr;
    logic [1:0] pp;
    logic [1:0] rp;
    string      tag;
  } vec_t;

  vec_t tbl[$];

  debounce_toggle_leds #(
    .NUM_CH           (2),
    .DEBOUNCE_CYCLES  (4),
    .SWITCH_ACTIVE_LOW(1),
    .TOGGLE_MASK      (2'b01)
  ) dut (
    .i_Clk          (clk),
    .i_Rst_n        (rst_n),
    .i_Switch       (sw),
    .i_Clear        (clr),
    .o_LED          (led),
    .o_Pressed      (pressed),
    .o_Press_Pulse  (press_pulse),
    .o_Release_Pulse(release_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] exp_v);
    logic [7:0] act_v;
    act_v = {led, pressed, press_pulse, release_pulse};
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL %s t=%0t got=%b expected=%b (led,pressed,press,release)",
               name, $time, act_v, exp_v);
    end
  endtask

  task automatic add(input int n, input logic [1:0] s, input logic c,
                     input logic [1:0] l, input logic [1:0] p,
                     input logic [1:0] pp, input logic [1:0] rp,
                     input string tag);
    vec_t v;
    v.sw = s; v.clr = c; v.led = l; v.pr = p; v.pp = pp; v.rp = rp; v.tag = tag;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Idle after reset with both switches released.
    add(20, 2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, "idle");
    // Ch0 toggle: press, release (LED on), press, release (LED off).
    add(5,  2'b10, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, "a1_press_wait");
    add(1,  2'b10, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, "a1_press_acc");
    add(14, 2'b10, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, "a1_press_hold");
    add(5,  2'b11, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, "a1_rel_wait");
    add(1,  2'b11, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01, "a1_rel_acc");
    add(14, 2'b11, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, "a1_rel_hold");
    add(5,  2'b10, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, "a2_press_wait");
    add(1,  2'b10, 1'b0, 2'b01, 2'b01, 2'b01, 2'b00, "a2_press_acc");
    add(14, 2'b10, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, "a2_press_hold");
    add(5,  2'b11, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, "a2_rel_wait");
    add(1,  2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, "a2_rel_acc");
    add(14, 2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, "a2_rel_hold");
    // Ch0 bounce: five bursts of 3 low / 3 high, never accepted.
    for (int b = 0; b < 5; b++) begin
      add(3, 2'b10, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, "b_bounce_low");
      add(3, 2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, "b_bounce_high");
    end
    add(10, 2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, "b_settle");
    // Ch1 momentary: LED follows pressed, clear has no effect.
    add(5,  2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, "c_press_wait");
    add(1,  2'b01, 1'b0, 2'b10, 2'b10, 2'b10, 2'b00, "c_press_acc");
    add(4,  2'b01, 1'b0, 2'b10, 2'b10, 2'b00, 2'b00, "c_press_hold");
    add(1,  2'b01, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00, "c_clear_mid");
    add(9,  2'b01, 1'b0, 2'b10, 2'b10, 2'b00, 2'b00, "c_press_hold2");
    add(5,  2'b11, 1'b0, 2'b10, 2'b10, 2'b00, 2'b00, "c_rel_wait");
    add(1,  2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b10, "c_rel_acc");
    add(14, 2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, "c_rel_hold");
    // Ch0 clear on the very edge its release is accepted.
    add(5,  2'b10, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, "d_press_wait");
    add(1,  2'b10, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, "d_press_acc");
    add(14, 2'b10, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, "d_press_hold");
    add(5,  2'b11, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, "d_rel_wait");
    add(1,  2'b11, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01, "d_clear_on_rel");
    add(14, 2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, "d_rel_hold");

    // Reset with both switches released.
    rst_n = 1'b0;
    sw    = 2'b11;
    clr   = 1'b0;
    #1;
    chk("reset_state", 8'b00_00_00_00);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_held", 8'b00_00_00_00);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      sw  = tbl[i].sw;
      clr = tbl[i].clr;
      tick();
      chk(tbl[i].tag, {tbl[i].led, tbl[i].pr, tbl[i].pp, tbl[i].rp});
    end
    clr = 1'b0;

    // Reset mid-debounce: ch1 held pressed (LED lit), ch0 two counts in.
    sw = 2'b01;
    repeat (10) tick();
    chk("e_ch1_held", 8'b10_10_00_00);
    sw = 2'b00;
    repeat (4) tick();
    chk("e_ch0_counting", 8'b10_10_00_00);
    rst_n = 1'b0;
    #1;
    chk("e_async_reset", 8'b00_00_00_00);
    repeat (2) tick();
    chk("e_reset_held", 8'b00_00_00_00);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("e_requal_wait", 8'b00_00_00_00);
    end
    tick();
    chk("e_requal_acc", 8'b10_11_11_00);
    tick();
    chk("e_requal_hold", 8'b10_11_00_00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
